// File: rtl/awg_pkg.sv
// Shared state encoding, sweep-mode constants and datapath widths for the AWG
// sweep controller and its dwell timer.
package awg_pkg;
    localparam int FREQ_W  = 12;
    localparam int AMP_W   = 3;
    localparam int PHASE_W = 8;
    localparam int DWELL_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_SWEEP = 2'd2,
        ST_DONE  = 2'd3
    } awg_state_e;

    localparam logic [1:0] MODE_SINGLE = 2'd0;
    localparam logic [1:0] MODE_REPEAT = 2'd1;
    localparam logic [1:0] MODE_TRI    = 2'd2;
endpackage

// File: rtl/awg_sweep_ctrl_if.sv
// Configuration handshake bus: the host offers a sweep description with
// cfg_valid, and the controller accepts it while cfg_ready is high.
interface awg_sweep_ctrl_if;
    import awg_pkg::*;

    logic               cfg_valid;
    logic               cfg_ready;
    logic [FREQ_W-1:0]  cfg_f_start;
    logic [FREQ_W-1:0]  cfg_f_stop;
    logic [FREQ_W-1:0]  cfg_f_step;
    logic [DWELL_W-1:0] cfg_dwell;
    logic [1:0]         cfg_mode;
    logic [AMP_W-1:0]   cfg_amp;
    logic [PHASE_W-1:0] cfg_phase;

    modport master (
        output cfg_valid, cfg_f_start, cfg_f_stop, cfg_f_step, cfg_dwell,
               cfg_mode, cfg_amp, cfg_phase,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid, cfg_f_start, cfg_f_stop, cfg_f_step, cfg_dwell,
               cfg_mode, cfg_amp, cfg_phase,
        output cfg_ready
    );
endinterface

// File: rtl/awg_dwell_timer.sv
// Dwell down-counter: load sets the hold length, count decrements it, and
// expire marks the last cycle of the current frequency.
module awg_dwell_timer
    import awg_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [DWELL_W-1:0] load_val,
    input  logic               count,
    output logic               expire
);
    logic [DWELL_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (count && (cnt != '0)) begin
            cnt <= cnt - DWELL_W'(1);
        end
    end

    assign expire = (cnt == '0);
endmodule

// File: rtl/awg_sweep_ctrl.sv
// Frequency sweep sequencer for a waveform generator: accepts a sweep config,
// then steps freq between f_start and f_stop in single, repeat or triangle mode.
module awg_sweep_ctrl
    import awg_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    awg_sweep_ctrl_if.slave     cfg,
    input  logic                start,
    input  logic                abort,
    output logic                en,
    output logic [FREQ_W-1:0]   freq,
    output logic [AMP_W-1:0]    amp,
    output logic [PHASE_W-1:0]  phase,
    output logic                busy,
    output logic                done
);
    awg_state_e         state, state_nxt;
    logic [FREQ_W-1:0]  f_start_q, f_stop_q, f_step_q;
    logic [DWELL_W-1:0] dwell_q;
    logic [1:0]         mode_q;
    logic [AMP_W-1:0]   amp_q;
    logic [PHASE_W-1:0] phase_q;
    logic               cfg_ready_q;
    logic               dir_dn, dir_dn_nxt;
    logic [FREQ_W-1:0]  freq_nxt;
    logic               en_nxt, busy_nxt, done_nxt, cfg_ready_nxt;
    logic [AMP_W-1:0]   amp_nxt;
    logic [PHASE_W-1:0] phase_nxt;
    logic               hs, expire, tmr_load;
    logic               degenerate, at_top, at_bottom, single;

    // Upward step computed one bit wide so a large step cannot wrap past f_stop.
    function automatic logic [FREQ_W-1:0] step_up(input logic [FREQ_W-1:0] f,
                                                  input logic [FREQ_W-1:0] step,
                                                  input logic [FREQ_W-1:0] ceil_f);
        logic [FREQ_W:0] nxt;
        nxt = {1'b0, f} + {1'b0, step};
        return (nxt >= {1'b0, ceil_f}) ? ceil_f : nxt[FREQ_W-1:0];
    endfunction

    function automatic logic [FREQ_W-1:0] step_dn(input logic [FREQ_W-1:0] f,
                                                  input logic [FREQ_W-1:0] step,
                                                  input logic [FREQ_W-1:0] floor_f);
        logic signed [FREQ_W:0] nxt;
        nxt = $signed({1'b0, f}) - $signed({1'b0, step});
        return (nxt <= $signed({1'b0, floor_f})) ? floor_f : nxt[FREQ_W-1:0];
    endfunction

    assign hs            = cfg.cfg_valid && cfg_ready_q;
    assign cfg.cfg_ready = cfg_ready_q;
    assign degenerate    = (f_stop_q <= f_start_q);
    assign at_top        = !dir_dn && (freq >= f_stop_q);
    assign at_bottom     = dir_dn && (freq <= f_start_q);
    assign single        = (mode_q != MODE_REPEAT) && (mode_q != MODE_TRI);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            f_start_q <= '0;
            f_stop_q  <= '0;
            f_step_q  <= '0;
            dwell_q   <= '0;
            mode_q    <= MODE_SINGLE;
            amp_q     <= '0;
            phase_q   <= '0;
        end else if (hs) begin
            f_start_q <= cfg.cfg_f_start;
            f_stop_q  <= cfg.cfg_f_stop;
            f_step_q  <= (cfg.cfg_f_step == '0) ? FREQ_W'(1) : cfg.cfg_f_step;
            dwell_q   <= cfg.cfg_dwell;
            mode_q    <= cfg.cfg_mode;
            amp_q     <= cfg.cfg_amp;
            phase_q   <= cfg.cfg_phase;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (hs) state_nxt = ST_ARMED;
            ST_ARMED: if (!hs && start && !abort) state_nxt = ST_SWEEP;
            ST_SWEEP: begin
                if (abort) state_nxt = ST_ARMED;
                else if (expire && at_top && single) state_nxt = ST_DONE;
            end
            ST_DONE:  state_nxt = ST_ARMED;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Frequency walk: reload the dwell timer on entry and at every frequency change.
    always_comb begin
        freq_nxt   = freq;
        dir_dn_nxt = dir_dn;
        tmr_load   = 1'b0;
        if (state_nxt != ST_SWEEP) begin
            freq_nxt   = '0;
            dir_dn_nxt = 1'b0;
        end else if (state != ST_SWEEP) begin
            freq_nxt   = f_start_q;
            dir_dn_nxt = 1'b0;
            tmr_load   = 1'b1;
        end else if (expire) begin
            tmr_load = 1'b1;
            if (degenerate) begin
                freq_nxt = f_start_q;
            end else if (at_top) begin
                if (mode_q == MODE_TRI) begin
                    dir_dn_nxt = 1'b1;
                    freq_nxt   = step_dn(freq, f_step_q, f_start_q);
                end else begin
                    freq_nxt = f_start_q;
                end
            end else if (at_bottom) begin
                dir_dn_nxt = 1'b0;
                freq_nxt   = step_up(freq, f_step_q, f_stop_q);
            end else if (dir_dn) begin
                freq_nxt = step_dn(freq, f_step_q, f_start_q);
            end else begin
                freq_nxt = step_up(freq, f_step_q, f_stop_q);
            end
        end
    end

    always_comb begin
        en_nxt        = (state_nxt == ST_SWEEP);
        busy_nxt      = (state_nxt == ST_SWEEP);
        done_nxt      = (state_nxt == ST_DONE);
        cfg_ready_nxt = (state_nxt == ST_IDLE) || (state_nxt == ST_ARMED);
        amp_nxt       = en_nxt ? amp_q : AMP_W'(1);
        phase_nxt     = en_nxt ? phase_q : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            freq        <= '0;
            dir_dn      <= 1'b0;
            en          <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            amp         <= AMP_W'(1);
            phase       <= '0;
            cfg_ready_q <= 1'b1;
        end else begin
            freq        <= freq_nxt;
            dir_dn      <= dir_dn_nxt;
            en          <= en_nxt;
            busy        <= busy_nxt;
            done        <= done_nxt;
            amp         <= amp_nxt;
            phase       <= phase_nxt;
            cfg_ready_q <= cfg_ready_nxt;
        end
    end

    awg_dwell_timer u_dwell (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (dwell_q),
        .count    (state == ST_SWEEP),
        .expire   (expire)
    );
endmodule

// File: tb/tb_awg_sweep_ctrl.sv
// Bench for awg_sweep_ctrl: list-based sweep model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_awg_sweep_ctrl;
    localparam int S_IDLE = 0, S_ARMED = 1, S_SWEEP = 2, S_DONE = 3;

    logic        clk, rst, start, abort;
    logic        en, busy, done;
    logic [11:0] freq;
    logic [2:0]  amp;
    logic [7:0]  phase;

    awg_sweep_ctrl_if cif();

    awg_sweep_ctrl dut (
        .clk   (clk),
        .rst   (rst),
        .cfg   (cif),
        .start (start),
        .abort (abort),
        .en    (en),
        .freq  (freq),
        .amp   (amp),
        .phase (phase),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: the sweep is the list of frequency points visited,
    // each held for dwell+1 cycles; k counts cycles since the sweep began.
    int m_state = S_IDLE;
    int m_fs = 0, m_fe = 0, m_st = 0, m_dw = 0, m_md = 0, m_amp = 0, m_ph = 0;
    int m_k = 0;
    int seq[$];

    function automatic void build_seq();
        int f;
        seq.delete();
        f = m_fs;
        seq.push_back(f);
        while (f < m_fe) begin
            f = (f + m_st >= m_fe) ? m_fe : f + m_st;
            seq.push_back(f);
        end
        if (m_md == 2 && seq.size() > 1) begin
            f = m_fe - m_st;
            while (f > m_fs) begin
                seq.push_back(f);
                f -= m_st;
            end
        end
    endfunction

    task automatic model_step();
        bit hs;
        hs = cif.cfg_valid && (m_state == S_IDLE || m_state == S_ARMED);
        if (hs) begin
            m_fs = cif.cfg_f_start; m_fe = cif.cfg_f_stop;
            m_st = (cif.cfg_f_step == 0) ? 1 : int'(cif.cfg_f_step);
            m_dw = cif.cfg_dwell; m_md = (cif.cfg_mode == 3) ? 0 : int'(cif.cfg_mode);
            m_amp = cif.cfg_amp; m_ph = cif.cfg_phase;
            m_state = S_ARMED;
        end else begin
            case (m_state)
                S_ARMED: if (start && !abort) begin
                    build_seq();
                    m_k = 0;
                    m_state = S_SWEEP;
                end
                S_SWEEP: begin
                    if (abort) m_state = S_ARMED;
                    else begin
                        m_k++;
                        if (m_md == 0 && m_k == seq.size() * (m_dw + 1)) m_state = S_DONE;
                    end
                end
                S_DONE: m_state = S_ARMED;
                default: ;
            endcase
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_state = S_IDLE;
            m_fs = 0; m_fe = 0; m_st = 0; m_dw = 0; m_md = 0; m_amp = 0; m_ph = 0;
        end else begin
            model_step();
        end
    end

    always @(negedge clk) begin
        int idx;
        bit e_en;
        int e_freq;
        e_en = (m_state == S_SWEEP);
        e_freq = 0;
        if (e_en) begin
            idx = m_k / (m_dw + 1);
            if (m_md != 0) idx = idx % seq.size();
            if (idx < seq.size()) e_freq = seq[idx];
        end
        chk("en", en, e_en);
        chk("freq", freq, e_freq);
        chk("amp", amp, e_en ? m_amp : 1);
        chk("phase", phase, e_en ? m_ph : 0);
        chk("busy", busy, e_en);
        chk("done", done, m_state == S_DONE);
        chk("cfg_ready", cif.cfg_ready, m_state == S_IDLE || m_state == S_ARMED);
    end

    task automatic do_cfg(input int fs, input int fe, input int st, input int dw,
                          input int md, input int am, input int ph);
        cif.cfg_valid = 1'b1;
        cif.cfg_f_start = 12'(fs); cif.cfg_f_stop = 12'(fe); cif.cfg_f_step = 12'(st);
        cif.cfg_dwell = 16'(dw); cif.cfg_mode = 2'(md);
        cif.cfg_amp = 3'(am); cif.cfg_phase = 8'(ph);
        @(negedge clk);
        cif.cfg_valid = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic do_abort();
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
    endtask

    int tri_exp[6];

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        cif.cfg_valid = 1'b0; cif.cfg_f_start = '0; cif.cfg_f_stop = '0; cif.cfg_f_step = '0;
        cif.cfg_dwell = '0; cif.cfg_mode = '0; cif.cfg_amp = '0; cif.cfg_phase = '0;
        tri_exp = '{100, 200, 300, 200, 100, 200};
        @(negedge clk); @(negedge clk);
        chk("rst_ready", cif.cfg_ready, 1);
        chk("rst_amp", amp, 1);
        chk("rst_en", en, 0);
        rst = 1'b0;
        @(negedge clk);

        // Single-up sweep 100..400 step 100, four cycles per point
        do_cfg(100, 400, 100, 3, 0, 5, 8'hA5);
        do_start();
        for (int c = 0; c < 16; c++) begin
            chk("m0_freq", freq, 100 * (c / 4 + 1));
            chk("m0_amp", amp, 5);
            chk("m0_phase", phase, 8'hA5);
            @(negedge clk);
        end
        chk("m0_done", done, 1);
        chk("m0_done_en", en, 0);
        @(negedge clk);
        chk("m0_done_clear", done, 0);
        chk("m0_armed_rdy", cif.cfg_ready, 1);

        // Overshoot clamps to 4095 instead of wrapping
        do_cfg(4000, 4095, 200, 1, 0, 3, 8'h11);
        do_start();
        for (int c = 0; c < 4; c++) begin
            chk("ovs_freq", freq, (c < 2) ? 4000 : 4095);
            @(negedge clk);
        end
        chk("ovs_done", done, 1);
        @(negedge clk);

        // Triangle 100..300 step 100, dwell 0
        do_cfg(100, 300, 100, 0, 2, 2, 8'h3C);
        do_start();
        for (int c = 0; c < 6; c++) begin
            chk("tri_freq", freq, tri_exp[c]);
            chk("tri_done", done, 0);
            @(negedge clk);
        end
        repeat (12) @(negedge clk);
        do_abort();
        chk("tri_abort_en", en, 0);

        // Abort on the second dwell cycle of 200, then restart
        do_cfg(100, 400, 100, 3, 0, 6, 8'h42);
        do_start();
        repeat (5) @(negedge clk);
        chk("ab_pre_freq", freq, 200);
        do_abort();
        chk("ab_en", en, 0);
        chk("ab_freq", freq, 0);
        chk("ab_busy", busy, 0);
        chk("ab_done", done, 0);
        chk("ab_ready", cif.cfg_ready, 1);
        do_start();
        chk("ab_restart_freq", freq, 100);
        chk("ab_restart_en", en, 1);
        do_abort();

        // Start and abort together in ARMED
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk("sa_en", en, 0);
        chk("sa_ready", cif.cfg_ready, 1);
        @(negedge clk);
        chk("sa_en2", en, 0);

        // Reset mid-sweep, start ignored in IDLE, zero step walks by 1
        do_start();
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mr_en", en, 0);
        chk("mr_freq", freq, 0);
        chk("mr_busy", busy, 0);
        chk("mr_amp", amp, 1);
        chk("mr_ready", cif.cfg_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        do_start();
        chk("mr_idle_en", en, 0);
        do_cfg(10, 13, 0, 0, 0, 7, 8'h01);
        do_start();
        for (int c = 0; c < 4; c++) begin
            chk("z_freq", freq, 10 + c);
            @(negedge clk);
        end
        chk("z_done", done, 1);
        @(negedge clk);

        // Randomized traffic against the model
        for (int i = 0; i < 6000; i++) begin
            cif.cfg_valid = ($urandom % 6 == 0);
            if (cif.cfg_valid) begin
                cif.cfg_f_start = 12'($urandom % 4096);
                cif.cfg_f_stop  = 12'($urandom % 4096);
                cif.cfg_f_step  = ($urandom % 8 == 0) ? 12'd0 : 12'($urandom_range(150, 2000));
                cif.cfg_dwell   = 16'($urandom % 4);
                cif.cfg_mode    = 2'($urandom % 4);
                cif.cfg_amp     = 3'($urandom % 8);
                cif.cfg_phase   = 8'($urandom % 256);
            end
            start = ($urandom % 4 == 0);
            abort = ($urandom % 40 == 0);
            #2 rst = ($urandom % 400 == 0);
            @(negedge clk);
        end
        cif.cfg_valid = 1'b0; start = 1'b0; abort = 1'b0;
        #2 rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule

// File: doc/awg_sweep_ctrl.md
AWG_SWEEP_CTRL -- requirements
Module: awg_sweep_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, all logic on rising edge.
REQ-002 SHALL have ports: rst  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have ports: cfg_valid in 1, cfg_ready out 1  config handshake; transfer when both high on a clk edge.
REQ-004 SHALL have ports: cfg_f_start, cfg_f_stop, cfg_f_step  in  12 each  sweep start, stop and step phase-increments.
REQ-005 SHALL have ports: cfg_dwell  in  16  hold cycles per frequency, minus one.
REQ-006 SHALL have ports: cfg_mode  in  2  0 single-up, 1 repeat-up, 2 triangle, 3 treated as 0.
REQ-007 SHALL have ports: cfg_amp in 3, cfg_phase in 8  passed through to the generator.
REQ-008 SHALL have ports: start in 1, abort in 1  single-cycle command pulses.
REQ-009 SHALL have ports: en out 1, freq out 12, amp out 3, phase out 8  drive the waveform generator.
REQ-010 SHALL have ports: busy out 1 (high in SWEEP), done out 1 (one-cycle completion pulse).

Function
REQ-011 SHALL implement the states IDLE (no config), ARMED (config held), SWEEP and DONE.
REQ-012 SHALL drive cfg_ready high in IDLE and ARMED only, and low in SWEEP and DONE.
REQ-013 SHALL latch all cfg_* fields on a handshake, with zero-step stored as 1; IDLE/ARMED -> ARMED.
REQ-014 SHALL, on start in ARMED at edge N, enter SWEEP with freq=f_start, en=1 and busy=1 visible after edge N; start in any other state is ignored.
REQ-015 SHALL ignore start when a cfg handshake occurs on the same edge; the new config is latched.
REQ-016 SHALL hold each frequency for exactly dwell+1 cycles, timed by a down-counter reloaded at every frequency change.
REQ-017 SHALL step up by computing next=freq+step in 13 bits; if next>=f_stop, freq becomes f_stop for a final dwell, with no 12-bit wrap.
REQ-018 SHALL step down in triangle mode as freq-step in 13 signed bits; if the result <=f_start, freq becomes f_start.
REQ-019 SHALL, in mode 0, go SWEEP -> DONE after the f_stop dwell ends; DONE lasts one cycle with done=1 and en=0, then goes to ARMED.
REQ-020 SHALL, in mode 1, return freq to f_start after the f_stop dwell and never assert done.
REQ-021 SHALL, in mode 2, reverse direction at f_stop and at f_start (each endpoint dwelled once per pass) and never assert done.
REQ-022 SHALL, when f_stop<=f_start, hold f_start for one dwell, then act as the endpoint reached (mode 0 done; modes 1/2 repeat).
REQ-023 SHALL, on abort in SWEEP/DONE, go to ARMED on the next edge with en=0, freq=0, busy=0, no done pulse and config retained; abort wins over start.
REQ-024 SHALL drive amp=cfg_amp and phase=cfg_phase from the latched config whenever en=1, and amp=1, phase=0 otherwise.
REQ-025 SHALL register all outputs, with no combinational input-to-output paths.

Reset
REQ-026 SHALL, on rst high, enter IDLE immediately and clear the latched config.
REQ-027 SHALL drive these reset output values: en=0, freq=0, amp=1, phase=0, busy=0, done=0, cfg_ready=1.
REQ-028 SHALL, on rst asserted mid-sweep, drop en within the same cycle with no done pulse; the first edge after release sees IDLE.

Structure
REQ-029 SHALL take from shared package awg_pkg: the state encoding, the mode constants, and widths FREQ_W=12, AMP_W=3, PHASE_W=8, DWELL_W=16.
REQ-030 SHALL instantiate one sub-module, awg_dwell_timer (load, count, expire), for the dwell counter.

Verification
REQ-031 SHALL cover mode 0 with f_start=100, f_stop=400, step=100, dwell=3: freq runs 100,200,300,400, 4 cycles each; done pulses 1 cycle later; back in ARMED.
REQ-032 SHALL cover overshoot with f_start=4000, f_stop=4095, step=200: freq goes 4000 -> 4095 (no wrap); done after 2 dwells.
REQ-033 SHALL cover mode 2 with 100/300/step 100/dwell 0: freq runs 100,200,300,200,100,200... and done is never asserted.
REQ-034 SHALL cover abort on the 2nd dwell cycle of freq=200: next cycle en=0, freq=0, busy=0, ARMED; a later start restarts at 100.
REQ-035 SHALL cover start and abort on the same edge in ARMED: the block stays ARMED and en stays 0.
REQ-036 SHALL cover rst pulsed mid-sweep: outputs take reset values immediately, start is ignored until a new cfg handshake, and step=0 config is stepped as 1.
